// File: rtl/duc_core_if.sv
// Stream bundle for the digital up-converter: baseband samples in, phase
// configuration in, up-converted IF samples out.
interface duc_core_if;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [64:0] s_phase_tdata;
    logic        s_phase_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid,
        output s_axis_tready,
        input  s_phase_tdata, s_phase_tvalid,
        output m_axis_tdata, m_axis_tvalid,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid,
        input  s_axis_tready,
        output s_phase_tdata, s_phase_tvalid,
        input  m_axis_tdata, m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/duc_core.sv
// Digital up-converter: mixes baseband I/Q with an NCO (phase accumulator plus
// sin/cos ROM) and emits out_i = I*cos - Q*sin, out_q = I*sin + Q*cos through a
// five-stage pipeline that freezes as a whole under output backpressure.
module duc_core #(
    parameter int unsigned LUT_BITS = 10
) (
    input  logic      clk,
    input  logic      rst,
    duc_core_if.slave bus
);
    localparam int unsigned LUT_DEPTH = 2 ** LUT_BITS;
    localparam real         PI        = 3.14159265358979323846;

    // round(32767 * sin) or round(32767 * cos) of table entry n; cos is taken
    // as sin shifted a quarter turn, and the angle is folded into [-pi, pi)
    // so the Taylor series stays well conditioned.
    function automatic logic [15:0] trig_word(input int unsigned n, input logic is_cos);
        int  m;
        int  r;
        real x;
        real term;
        real sum;
        real v;
        m = int'(is_cos ? (n + LUT_DEPTH / 4) % LUT_DEPTH : n);
        if (m >= int'(LUT_DEPTH / 2))
            m = m - int'(LUT_DEPTH);
        x    = 2.0 * PI * real'(m) / real'(LUT_DEPTH);
        term = x;
        sum  = x;
        for (int unsigned k = 1; k < 40; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        v = 32767.0 * sum;
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        return r[15:0];
    endfunction

    // Add half an LSB of the output scale, then keep bits [30:15] unless the
    // top three bits disagree, in which case clamp toward the sign.
    function automatic logic [15:0] round_sat(input logic [32:0] sum);
        logic [32:0] r;
        r = sum + 33'd16384;
        if (r[32:30] == 3'b000 || r[32:30] == 3'b111)
            return r[30:15];
        return r[32] ? 16'h8000 : 16'h7fff;
    endfunction

    logic [31:0] rom [LUT_DEPTH];

    for (genvar n = 0; n < LUT_DEPTH; n++) begin : g_rom
        assign rom[n] = {trig_word(n, 1'b0), trig_word(n, 1'b1)};
    end

    logic [31:0] acc;
    logic [31:0] pinc;
    logic [31:0] poff;
    logic        p_conf;
    logic        stall;
    logic        accept;
    logic [31:0] phase;

    logic                s1_valid;
    logic [LUT_BITS-1:0] s1_idx;
    logic signed [15:0]  s1_i;
    logic signed [15:0]  s1_q;
    logic                s2_valid;
    logic [31:0]         s2_rom;
    logic signed [15:0]  s2_i;
    logic signed [15:0]  s2_q;
    logic signed [15:0]  s2_sin;
    logic signed [15:0]  s2_cos;
    logic                s3_valid;
    logic signed [31:0]  s3_ic;
    logic signed [31:0]  s3_qs;
    logic signed [31:0]  s3_is;
    logic signed [31:0]  s3_qc;
    logic                s4_valid;
    logic [32:0]         s4_sum_i;
    logic [32:0]         s4_sum_q;

    assign stall             = bus.m_axis_tvalid & ~bus.m_axis_tready;
    assign bus.s_axis_tready = p_conf & ~stall;
    assign accept            = bus.s_axis_tvalid & bus.s_axis_tready;
    assign phase             = acc + poff;
    assign s2_sin            = s2_rom[31:16];
    assign s2_cos            = s2_rom[15:0];

    // NCO state: accumulate on accepted samples; a config strobe reloads
    // pinc/poff and a resync clears acc, overriding that cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            pinc   <= '0;
            poff   <= '0;
            p_conf <= 1'b0;
        end else begin
            if (accept)
                acc <= acc + pinc;
            if (bus.s_phase_tvalid) begin
                pinc   <= bus.s_phase_tdata[31:0];
                poff   <= bus.s_phase_tdata[63:32];
                p_conf <= 1'b1;
                if (bus.s_phase_tdata[64])
                    acc <= '0;
            end
        end
    end

    // Registered ROM read, kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!stall)
            s2_rom <= rom[s1_idx];
    end

    // Datapath stages S1..S5; every stage holds while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid          <= 1'b0;
            s1_idx            <= '0;
            s1_i              <= '0;
            s1_q              <= '0;
            s2_valid          <= 1'b0;
            s2_i              <= '0;
            s2_q              <= '0;
            s3_valid          <= 1'b0;
            s3_ic             <= '0;
            s3_qs             <= '0;
            s3_is             <= '0;
            s3_qc             <= '0;
            s4_valid          <= 1'b0;
            s4_sum_i          <= '0;
            s4_sum_q          <= '0;
            bus.m_axis_tvalid <= 1'b0;
            bus.m_axis_tdata  <= '0;
        end else if (!stall) begin
            s1_valid          <= accept;
            s1_idx            <= phase[31 -: LUT_BITS];
            s1_i              <= bus.s_axis_tdata[15:0];
            s1_q              <= bus.s_axis_tdata[31:16];
            s2_valid          <= s1_valid;
            s2_i              <= s1_i;
            s2_q              <= s1_q;
            s3_valid          <= s2_valid;
            s3_ic             <= s2_i * s2_cos;
            s3_qs             <= s2_q * s2_sin;
            s3_is             <= s2_i * s2_sin;
            s3_qc             <= s2_q * s2_cos;
            s4_valid          <= s3_valid;
            s4_sum_i          <= {s3_ic[31], s3_ic} - {s3_qs[31], s3_qs};
            s4_sum_q          <= {s3_is[31], s3_is} + {s3_qc[31], s3_qc};
            bus.m_axis_tvalid <= s4_valid;
            bus.m_axis_tdata  <= {round_sat(s4_sum_q), round_sat(s4_sum_i)};
        end
    end
endmodule
